// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for param_sync_ram
// Clear-sweep FSM state encoding and an even-parity helper.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  // Widest data word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 256;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - post-reset clear sweep over every RAM word
// Walks addresses 0..DEPTH-1 once, then reports done until the next reset.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              cl,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ad,
  output logic              done
);

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leave CLEAR by comparing against the last address so the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    clr_ad  = cnt_q;
    done    = (state_q == IDLE);
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        cnt_d = cnt_q;
      end
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: rtl/param_sync_ram.sv
// rtl/param_sync_ram.sv - parametrised single-port synchronous RAM with clear sweep
// Optional stored parity and perr output under PARAM_RAM_PARITY_EN.
module param_sync_ram
  import ram_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 8,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              cl,
  input  logic              rst_n,
  input  logic              st,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic              y_vld,
  output logic              rdy
`ifdef PARAM_RAM_PARITY_EN
  ,
  output logic              perr
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARAM_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_ad;
  logic              done;

  logic              we;
  logic [ADDR_W-1:0] wad;
  logic [DATA_W-1:0] wdata;
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rd_word;

  logic [DATA_W-1:0] y_q, y_d;
  logic              y_vld_q, y_vld_d;
  logic              perr_q, perr_d;

  ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .cl     (cl),
    .rst_n  (rst_n),
    .clr_we (clr_we),
    .clr_ad (clr_ad),
    .done   (done)
  );

  // User strobes only reach the array once the sweep has finished.
  always_comb begin
    we      = clr_we | (done & st);
    wad     = clr_we ? clr_ad : ad;
    wdata   = clr_we ? INIT_VAL : X;
`ifdef PARAM_RAM_PARITY_EN
    wword   = {even_parity(PAR_MAX_W'(wdata)), wdata};
`else
    wword   = wdata;
`endif
    rd_word = mem_q[ad];

    y_d     = y_q;
    y_vld_d = 1'b0;
    perr_d  = 1'b0;
    if (done && ld) begin
      y_vld_d = 1'b1;
      if (st) begin
        // Write-first: the incoming word bypasses the array and is trusted.
        y_d = X;
      end else begin
        y_d = rd_word[DATA_W-1:0];
`ifdef PARAM_RAM_PARITY_EN
        perr_d = rd_word[DATA_W] ^ even_parity(PAR_MAX_W'(rd_word[DATA_W-1:0]));
`endif
      end
    end
  end

  always_ff @(posedge cl) begin
    if (we) begin
      mem_q[wad] <= wword;
    end
  end

  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      y_vld_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      perr_q  <= perr_d;
    end
  end

  assign Y     = y_q;
  assign y_vld = y_vld_q;
  assign rdy   = done;
`ifdef PARAM_RAM_PARITY_EN
  assign perr  = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule
